// File: rtl/cache_pkg.sv
// Shared instruction-cache definitions: line geometry defaults, line/word
// typedefs and the fill-engine state encoding, reused by the L1 I-cache.
package cache_pkg;

  localparam int ADDR_WIDTH     = 14;
  localparam int DATA_WIDTH     = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE);

  typedef logic [DATA_WIDTH-1:0]                word_t;
  typedef logic [WORDS_PER_LINE*DATA_WIDTH-1:0] line_t;
  typedef logic [ADDR_WIDTH-1:0]                line_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/line_buffer.sv
// Line assembly buffer: one register per word of the line, written one word
// at a time by index, exposed as a single packed line (word i at [i*DW +: DW]).
module line_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_we,
  input  logic [$clog2(WORDS_PER_LINE)-1:0]    i_idx,
  input  logic [DATA_WIDTH-1:0]                i_wdata,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] o_line
);

  logic [DATA_WIDTH-1:0] r_words [WORDS_PER_LINE];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        r_words[i] <= '0;
      end
    end else if (i_we) begin
      r_words[i_idx] <= i_wdata;
    end
  end

  for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_pack
    assign o_line[g*DATA_WIDTH +: DATA_WIDTH] = r_words[g];
  end

endmodule

// File: rtl/imem_line_fill.sv
// Instruction-side line-fill engine: reads one aligned line from main-memory
// port 1 word by word, pacing on rising edges of memValid1, then pulses LINE_VALID.
module imem_line_fill #(
  parameter int ADDR_WIDTH     = cache_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = cache_pkg::DATA_WIDTH,
  parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 MISS,
  input  logic [ADDR_WIDTH-1:0]                MISS_ADDR,
  input  logic                                 FLUSH,
  output logic                                 BUSY,
  output logic                                 LINE_VALID,
  output logic [ADDR_WIDTH-1:0]                LINE_ADDR,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] LINE_DATA,
  output logic                                 MEM_RDEN1,
  output logic [ADDR_WIDTH-1:0]                MEM_ADDR1,
  input  logic [DATA_WIDTH-1:0]                MEM_DOUT1,
  input  logic                                 memValid1,
  output cache_pkg::fill_state_t               o_dbg_state
);

  import cache_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  // Handshakes: MISS is a request sampled only while IDLE (no queuing);
  // LINE_VALID is a one-cycle result pulse with no back-pressure; memValid1
  // is consumed on its rising edge only, so a held-high level counts once.

  fill_state_t             r_state;
  logic [IDX_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic                    r_valid_q;
  logic                    r_busy;
  logic                    r_line_valid;
  logic                    r_rden;

  logic                    w_capture;
  logic                    w_last;
  logic                    w_buf_we;
  logic [IDX_W-1:0]        w_cnt_next;
  logic [ADDR_WIDTH-1:0]   w_miss_base;

  assign w_capture   = memValid1 & ~r_valid_q;
  assign w_last      = (r_cnt == IDX_W'(WORDS_PER_LINE - 1));
  assign w_cnt_next  = r_cnt + IDX_W'(1);
  assign w_miss_base = MISS_ADDR & ~ADDR_WIDTH'(WORDS_PER_LINE - 1);
  // A FLUSH on the capture edge discards the word as well as the fill.
  assign w_buf_we    = (r_state == FETCH) && w_capture && !FLUSH;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_base       <= '0;
      r_mem_addr   <= '0;
      r_valid_q    <= 1'b0;
      r_busy       <= 1'b0;
      r_line_valid <= 1'b0;
      r_rden       <= 1'b0;
    end else begin
      r_valid_q <= memValid1;
      unique case (r_state)
        IDLE: begin
          if (MISS && !FLUSH) begin
            r_state    <= FETCH;
            r_base     <= w_miss_base;
            r_mem_addr <= w_miss_base;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_rden     <= 1'b1;
          end
        end
        FETCH: begin
          if (FLUSH) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_rden  <= 1'b0;
          end else if (w_capture) begin
            if (w_last) begin
              r_state      <= DONE;
              r_rden       <= 1'b0;
              r_line_valid <= 1'b1;
            end else begin
              r_cnt      <= w_cnt_next;
              r_mem_addr <= r_base | ADDR_WIDTH'(w_cnt_next);
            end
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_line_valid <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_line_valid <= 1'b0;
          r_rden       <= 1'b0;
        end
      endcase
    end
  end

  line_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_line_buffer (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_we   (w_buf_we),
    .i_idx  (r_cnt),
    .i_wdata(MEM_DOUT1),
    .o_line (LINE_DATA)
  );

  assign BUSY        = r_busy;
  assign LINE_VALID  = r_line_valid;
  assign LINE_ADDR   = r_base;
  assign MEM_RDEN1   = r_rden;
  assign MEM_ADDR1   = r_mem_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_line_fill.sv
// Bench for imem_line_fill: a delayed-valid memory model, an address-trace and
// line monitor, and per-scenario tasks checked against an arithmetic line model.
module tb_imem_line_fill;
  import cache_pkg::*;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int WPL = 8;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                MISS = 1'b0;
  logic [AW-1:0]       MISS_ADDR = '0;
  logic                FLUSH = 1'b0;
  logic                BUSY;
  logic                LINE_VALID;
  logic [AW-1:0]       LINE_ADDR;
  logic [WPL*DW-1:0]   LINE_DATA;
  logic                MEM_RDEN1;
  logic [AW-1:0]       MEM_ADDR1;
  logic [DW-1:0]       MEM_DOUT1 = '0;
  logic                memValid1 = 1'b0;
  fill_state_t         dbg_state;

  int checks = 0;
  int errors = 0;

  // memory model controls and state
  int            hold_cycles = 1;
  int            fixed_delay = 0;
  bit            m_active = 1'b0;
  logic [AW-1:0] m_addr = '0;
  int            m_wait = 0;
  int            m_hold = 0;

  // scoreboard / monitor state
  logic [AW-1:0]     exp_q[$];
  logic [AW-1:0]     obs_q[$];
  int                lv_count = 0;
  logic [AW-1:0]     got_addr = '0;
  logic [WPL*DW-1:0] got_data = '0;
  bit                mon_rden_q = 1'b0;
  logic [AW-1:0]     mon_addr_q = '0;

  imem_line_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
    .CLK(CLK), .RST(RST), .MISS(MISS), .MISS_ADDR(MISS_ADDR), .FLUSH(FLUSH),
    .BUSY(BUSY), .LINE_VALID(LINE_VALID), .LINE_ADDR(LINE_ADDR), .LINE_DATA(LINE_DATA),
    .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1),
    .memValid1(memValid1), .o_dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Memory: after a new address, waits a delay, then raises valid for hold_cycles.
  always @(negedge CLK) begin
    if (RST) begin
      m_active = 1'b0; m_wait = 0; m_hold = 0; memValid1 = 1'b0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin memValid1 = 1'b0; MEM_DOUT1 = $urandom; end
    end else if (MEM_RDEN1) begin
      if (!m_active || MEM_ADDR1 != m_addr) begin
        m_active = 1'b1; m_addr = MEM_ADDR1;
        m_wait = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 7));
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          memValid1 = 1'b1; MEM_DOUT1 = 32'hA000_0000 + 32'(m_addr); m_hold = hold_cycles;
        end
      end
    end else begin
      m_active = 1'b0;
    end
  end

  always @(posedge CLK) begin
    #2;
    if (!RST) begin
      if (MEM_RDEN1 && (!mon_rden_q || MEM_ADDR1 != mon_addr_q)) obs_q.push_back(MEM_ADDR1);
      mon_rden_q = MEM_RDEN1; mon_addr_q = MEM_ADDR1;
      if (LINE_VALID) begin lv_count++; got_addr = LINE_ADDR; got_data = LINE_DATA; end
    end else begin
      mon_rden_q = 1'b0;
    end
  end

  function automatic int line_base(input logic [AW-1:0] a);
    return (int'(a) / WPL) * WPL;
  endfunction

  function automatic logic [WPL*DW-1:0] exp_line(input logic [AW-1:0] a);
    logic [WPL*DW-1:0] l;
    int b;
    b = line_base(a);
    for (int i = 0; i < WPL; i++) l[i*DW +: DW] = 32'hA000_0000 + 32'(b + i);
    return l;
  endfunction

  function automatic int trace_errs();
    int n;
    n = (obs_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic prep(input logic [AW-1:0] a);
    exp_q.delete(); obs_q.delete(); lv_count = 0;
    for (int i = 0; i < WPL; i++) exp_q.push_back(AW'(line_base(a) + i));
  endtask

  task automatic start_fill(input logic [AW-1:0] a);
    MISS = 1'b1; MISS_ADDR = a;
    @(negedge CLK);
    MISS = 1'b0; MISS_ADDR = AW'($urandom);
  endtask

  task automatic wait_line(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 600; i++) begin
      if (lv_count > 0) begin ok = 1'b1; cyc = i; break; end
      @(negedge CLK);
    end
  endtask

  task automatic wait_trace(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (obs_q.size() == n) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (LINE_VALID !== 1'b0) begin errors++; $display("FAIL reset_lv: got %b want 0", LINE_VALID); end
    checks++; if (LINE_ADDR !== '0) begin errors++; $display("FAIL reset_line_addr: got %h want 0", LINE_ADDR); end
    checks++; if (LINE_DATA !== '0) begin errors++; $display("FAIL reset_line_data: got %h want 0", LINE_DATA); end
    checks++; if (MEM_RDEN1 !== 1'b0 || MEM_ADDR1 !== '0) begin errors++; $display("FAIL reset_mem: got rden=%b addr=%h want 0/0", MEM_RDEN1, MEM_ADDR1); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_fill();
    bit ok; int cyc;
    fixed_delay = 3; hold_cycles = 1;
    prep(14'h0013);
    start_fill(14'h0013);
    checks++; if (BUSY !== 1'b1 || MEM_RDEN1 !== 1'b1 || MEM_ADDR1 !== 14'h0010) begin errors++; $display("FAIL basic_request: got busy=%b rden=%b addr=%h want 1/1/0010", BUSY, MEM_RDEN1, MEM_ADDR1); end
    wait_line(ok, cyc);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no LINE_VALID want one"); end
    // with a fixed 3-cycle memory delay each word costs 5 cycles, none lost in the engine
    checks++; if (cyc != 39) begin errors++; $display("FAIL basic_latency: got %0d want 39", cyc); end
    checks++; if (BUSY !== 1'b1 || MEM_RDEN1 !== 1'b0) begin errors++; $display("FAIL basic_done_cycle: got busy=%b rden=%b want 1/0", BUSY, MEM_RDEN1); end
    checks++; if (trace_errs() != 0) begin errors++; $display("FAIL basic_trace: got %0d bad (size %0d) want 0", trace_errs(), obs_q.size()); end
    checks++; if (got_addr !== 14'h0010) begin errors++; $display("FAIL basic_line_addr: got %h want 0010", got_addr); end
    checks++; if (got_data[3*DW +: DW] !== 32'hA000_0013) begin errors++; $display("FAIL basic_word3: got %h want a0000013", got_data[3*DW +: DW]); end
    checks++; if (got_data !== exp_line(14'h0013)) begin errors++; $display("FAIL basic_line_data: got %h want %h", got_data, exp_line(14'h0013)); end
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0 || LINE_VALID !== 1'b0 || lv_count != 1) begin errors++; $display("FAIL basic_after: got busy=%b lv=%b pulses=%0d want 0/0/1", BUSY, LINE_VALID, lv_count); end
    fixed_delay = 0;
  endtask

  task automatic test_held_high();
    bit ok; int cyc; logic [AW-1:0] a;
    hold_cycles = 3; a = AW'($urandom_range(0, 16'h3FFF));
    prep(a);
    start_fill(a);
    wait_line(ok, cyc);
    @(negedge CLK);
    checks++; if (!ok || lv_count != 1) begin errors++; $display("FAIL held_pulses: got ok=%b pulses=%0d want 1/1", ok, lv_count); end
    checks++; if (trace_errs() != 0) begin errors++; $display("FAIL held_trace: got %0d bad (size %0d) want 0", trace_errs(), obs_q.size()); end
    checks++; if (got_data !== exp_line(a)) begin errors++; $display("FAIL held_line_data: got %h want %h", got_data, exp_line(a)); end
    hold_cycles = 1;
  endtask

  task automatic test_ignored_miss();
    bit ok; int cyc;
    prep(14'h0010);
    start_fill(14'h0010);
    wait_trace(3, ok);
    MISS = 1'b1; MISS_ADDR = 14'h0100;
    @(negedge CLK);
    MISS = 1'b0;
    wait_line(ok, cyc);
    repeat (10) @(negedge CLK);
    checks++; if (!ok || lv_count != 1) begin errors++; $display("FAIL ignored_pulses: got ok=%b pulses=%0d want 1/1", ok, lv_count); end
    checks++; if (got_addr !== 14'h0010) begin errors++; $display("FAIL ignored_line_addr: got %h want 0010", got_addr); end
    checks++; if (trace_errs() != 0 || BUSY !== 1'b0) begin errors++; $display("FAIL ignored_trace: got %0d bad busy=%b want 0/0", trace_errs(), BUSY); end
  endtask

  task automatic test_flush();
    bit ok; int cyc;
    prep(14'h0050);
    start_fill(14'h0050);
    wait_trace(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_reach4: got trace size %0d want 5", obs_q.size()); end
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0 || MEM_RDEN1 !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL flush_idle: got busy=%b rden=%b state=%0d want 0/0/IDLE", BUSY, MEM_RDEN1, dbg_state); end
    repeat (20) @(negedge CLK);
    checks++; if (lv_count != 0) begin errors++; $display("FAIL flush_no_lv: got %0d pulses want 0", lv_count); end
    MISS = 1'b1; FLUSH = 1'b1; MISS_ADDR = 14'h0030;
    @(negedge CLK);
    MISS = 1'b0; FLUSH = 1'b0;
    checks++; if (BUSY !== 1'b0 || MEM_RDEN1 !== 1'b0) begin errors++; $display("FAIL miss_flush_idle: got busy=%b rden=%b want 0/0", BUSY, MEM_RDEN1); end
    prep(14'h0020);
    start_fill(14'h0020);
    wait_line(ok, cyc);
    @(negedge CLK);
    checks++; if (!ok || trace_errs() != 0 || got_addr !== 14'h0020) begin errors++; $display("FAIL flush_refill: got ok=%b bad=%0d addr=%h want 1/0/0020", ok, trace_errs(), got_addr); end
    checks++; if (got_data !== exp_line(14'h0020)) begin errors++; $display("FAIL flush_refill_data: got %h want %h", got_data, exp_line(14'h0020)); end
  endtask

  task automatic test_async_reset();
    bit ok; int cyc; logic [AW-1:0] a;
    prep(14'h0040);
    start_fill(14'h0040);
    wait_trace(6, ok);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++; if (!ok || BUSY !== 1'b0 || LINE_VALID !== 1'b0 || MEM_RDEN1 !== 1'b0) begin errors++; $display("FAIL areset_ctl: got ok=%b busy=%b lv=%b rden=%b want 1/0/0/0", ok, BUSY, LINE_VALID, MEM_RDEN1); end
    checks++; if (LINE_ADDR !== '0 || MEM_ADDR1 !== '0 || LINE_DATA !== '0) begin errors++; $display("FAIL areset_data: got la=%h ma=%h ld=%h want 0", LINE_ADDR, MEM_ADDR1, LINE_DATA); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    a = AW'($urandom_range(0, 16'h3FFF));
    prep(a);
    start_fill(a);
    wait_line(ok, cyc);
    @(negedge CLK);
    checks++; if (!ok || lv_count != 1 || trace_errs() != 0) begin errors++; $display("FAIL areset_refill: got ok=%b pulses=%0d bad=%0d want 1/1/0", ok, lv_count, trace_errs()); end
    checks++; if (got_data !== exp_line(a)) begin errors++; $display("FAIL areset_refill_data: got %h want %h", got_data, exp_line(a)); end
  endtask

  task automatic test_top_line();
    bit ok; int cyc;
    prep(14'h3FFD);
    start_fill(14'h3FFD);
    wait_line(ok, cyc);
    @(negedge CLK);
    checks++; if (!ok || trace_errs() != 0) begin errors++; $display("FAIL top_trace: got ok=%b bad=%0d want 1/0", ok, trace_errs()); end
    checks++; if (got_addr !== 14'h3FF8) begin errors++; $display("FAIL top_line_addr: got %h want 3ff8", got_addr); end
    checks++; if (got_data !== exp_line(14'h3FFD)) begin errors++; $display("FAIL top_line_data: got %h want %h", got_data, exp_line(14'h3FFD)); end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; logic [AW-1:0] a;
    for (int n = 0; n < 5; n++) begin
      a = AW'($urandom_range(0, 16'h3FFF));
      hold_cycles = $urandom_range(1, 3);
      prep(a);
      start_fill(a);
      checks++; if (BUSY !== 1'b1 || MEM_ADDR1 !== AW'(line_base(a))) begin errors++; $display("FAIL b2b_accept%0d: got busy=%b addr=%h want 1/%h", n, BUSY, MEM_ADDR1, AW'(line_base(a))); end
      wait_line(ok, cyc);
      @(negedge CLK);
      checks++; if (!ok || lv_count != 1 || trace_errs() != 0) begin errors++; $display("FAIL b2b_fill%0d: got ok=%b pulses=%0d bad=%0d want 1/1/0", n, ok, lv_count, trace_errs()); end
      checks++; if (got_addr !== AW'(line_base(a)) || got_data !== exp_line(a)) begin errors++; $display("FAIL b2b_line%0d: got %h/%h want %h/%h", n, got_addr, got_data, AW'(line_base(a)), exp_line(a)); end
    end
    hold_cycles = 1;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_held_high();
    test_ignored_miss();
    test_flush();
    test_async_reset();
    test_top_line();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
